btn_debounce: RTL and testbench

Front-end conditioning stage for the lab counter: synchronises a raw, bouncing push-button input to `clk` and filters contact bounce with a stability timer. It emits one single-cycle `press_pulse` per debounced press, which drives the counter's `en` input directly, plus a debounced level and a release strobe. An optional auto-repeat mode re-pulses while the button is held.

---
 rtl/btn_debounce_if.sv | 21 ++
 rtl/btn_debounce.sv | 138 +++++++++++++
 tb/tb_btn_debounce.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// Button conditioning bus: raw button toward the debouncer, conditioned strobes and level back.
interface btn_debounce_if;
  logic btn_in;
  logic press_pulse;
  logic btn_level;
  logic release_pulse;

  modport master (
    output btn_in,
    input  press_pulse,
    input  btn_level,
    input  release_pulse
  );

  modport slave (
    input  btn_in,
    output press_pulse,
    output btn_level,
    output release_pulse
  );
endinterface

// File: rtl/btn_debounce.sv
// Push-button synchroniser and debouncer producing press/release strobes and a debounced level.
// Optional auto-repeat of press_pulse while held is compiled in with `define BTN_REPEAT_EN.
module btn_debounce #(
  parameter int STABLE_CYCLES = 50000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input logic         clk,
  input logic         reset,
  btn_debounce_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  // Parameter legality is checked at elaboration so bad configurations never build.
  if (STABLE_CYCLES < 2) begin : g_bad_stable
    $error("btn_debounce: STABLE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("btn_debounce: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

`ifdef BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(REP_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] r_rep;
  logic          r_rep_period;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t        r_state;
  logic          r_s1;
  logic          r_s2;
  logic [CW-1:0] r_cnt;
  logic          r_press;
  logic          r_level;
  logic          r_release;

  assign bus.press_pulse   = r_press;
  assign bus.btn_level     = r_level;
  assign bus.release_pulse = r_release;

  // Strobes default low each cycle; only the qualifying transition raises one for a single cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_cnt     <= '0;
      r_state   <= IDLE;
      r_press   <= 1'b0;
      r_level   <= 1'b0;
      r_release <= 1'b0;
`ifdef BTN_REPEAT_EN
      r_rep        <= '0;
      r_rep_period <= 1'b0;
`endif
    end else begin
      r_s1      <= bus.btn_in;
      r_s2      <= r_s1;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_s2) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!r_s2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= HELD;
            r_cnt   <= '0;
            r_press <= 1'b1;
            r_level <= 1'b1;
`ifdef BTN_REPEAT_EN
            r_rep        <= '0;
            r_rep_period <= 1'b0;
`endif
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HELD: begin
          if (!r_s2) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= '0;
`ifdef BTN_REPEAT_EN
            r_rep        <= '0;
            r_rep_period <= 1'b0;
          end else if (r_rep == (r_rep_period ? PERIOD_LAST : DELAY_LAST)) begin
            r_press      <= 1'b1;
            r_rep        <= '0;
            r_rep_period <= 1'b1;
          end else begin
            r_rep <= r_rep + 1'b1;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (r_s2) begin
            // A release bounce resumes the hold without a fresh press strobe.
            r_state <= HELD;
            r_cnt   <= '0;
`ifdef BTN_REPEAT_EN
            r_rep        <= '0;
            r_rep_period <= 1'b1;
`endif
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_release <= 1'b1;
            r_level   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// [TB] Directed self-checking bench for btn_debounce with STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Expected repeat pulses follow whether BTN_REPEAT_EN is defined for the build.
module tb_btn_debounce;

`ifdef BTN_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vecCount = 0;
  int   missCount = 0;
  logic [2:0] got;
  logic [2:0] want;

  btn_debounce_if bus ();

  btn_debounce #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Drive one input value into the next rising edge, then stop on the following falling edge.
  task automatic tick(input logic v);
    bus.btn_in = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic settleLow();
    repeat (12) tick(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = 3'b000;
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL reset k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
    reset = 1'b0;
    tick(1'b0);
  endtask

  task automatic test_clean_press();
    for (int k = 0; k < 20; k++) begin
      tick(1'b1);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = {(k == 6) || (REP && k == 16), k >= 6, 1'b0};
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL clean_press k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
    for (int k = 0; k < 12; k++) begin
      tick(1'b0);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = {REP && k == 1, k < 6, k == 6};
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL clean_release k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_bounce();
    logic [5:0] pat;
    pat = 6'b101011;
    for (int k = 0; k < 16; k++) begin
      tick(k < 6 ? pat[k] : 1'b1);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = {k == 11, k >= 11, 1'b0};
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL bounce k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
    settleLow();
  endtask

  task automatic test_short_glitch();
    for (int k = 0; k < 12; k++) begin
      tick(k < 3 ? 1'b1 : 1'b0);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = 3'b000;
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL short_glitch k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    for (int k = 0; k < 7; k++) begin
      tick(1'b1);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = {k == 6, k >= 6, 1'b0};
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL pre_reset k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
    reset = 1'b1;
    tick(1'b1);
    got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
    want = 3'b000;
    vecCount++;
    if (got !== want) begin
      missCount++;
      $display("[TB] FAIL mid_reset {press,level,release} got %b want %b", got, want);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = {k == 6, k >= 6, 1'b0};
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL post_reset k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
    settleLow();
  endtask

  task automatic test_release_bounce();
    for (int k = 0; k < 20; k++) begin
      tick((k == 8 || k == 9) ? 1'b0 : 1'b1);
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = {(k == 6) || (REP && k == 17), k >= 6, 1'b0};
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL release_bounce k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
    settleLow();
  endtask

  task automatic test_hold_repeat();
    int o;
    for (int k = 0; k < 37; k++) begin
      tick(1'b1);
      o    = k - 6;
      got  = {bus.press_pulse, bus.btn_level, bus.release_pulse};
      want = {(o == 0) || (REP && (o == 10 || o == 15 || o == 20 || o == 25 || o == 30)),
              k >= 6, 1'b0};
      vecCount++;
      if (got !== want) begin
        missCount++;
        $display("[TB] FAIL hold_repeat k=%0d {press,level,release} got %b want %b", k, got, want);
      end
    end
    settleLow();
  endtask

  initial begin
    bus.btn_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_short_glitch();
    test_reset_mid_press();
    test_release_bounce();
    test_hold_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached got timeout want finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule
